// File: rtl/register_file_2r1w_pkg.sv
// register_file_2r1w_pkg: processor-wide widths, stack-pointer reset and the R0 zero constant
package register_file_2r1w_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int SP_INDEX = 29;
    localparam logic [DATA_WIDTH-1:0] SP_RESET = 32'h03FFFFFF;
    localparam logic [DATA_WIDTH-1:0] R0_ZERO = '0;
endpackage

// File: rtl/register_file_2r1w_register_32.sv
// register_32: load-enabled data flop with async active-low reset to a chosen value
module register_32
    import register_file_2r1w_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= RESET_VAL;
        else if (en) q <= d;
endmodule

// File: rtl/register_file_2r1w.sv
// register_file_2r1w: 32-entry 2-read/1-write register file with registered reads and write bypass
module register_file_2r1w
    import register_file_2r1w_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  R_VALID
);
    logic [DATA_WIDTH-1:0] entry [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd1, rd2;
    assign entry[0] = R0_ZERO;
    genvar i;
    generate
        for (i = 1; i < 2**ADDR_WIDTH; i++) begin : g_entry
            register_32 #(.RESET_VAL(i == SP_INDEX ? SP_RESET : R0_ZERO)) u_reg (
                .clk(CLK),
                .rst_n(RST),
                .en(WRITE && ADDR_W == ADDR_WIDTH'(i)),
                .d(DATA_W),
                .q(entry[i])
            );
        end
    endgenerate
    // address 0 short-circuits the bypass so a discarded R0 write never leaks through
    assign rd1 = ADDR_R1 == '0 ? R0_ZERO : (WRITE && ADDR_W == ADDR_R1) ? DATA_W : entry[ADDR_R1];
    assign rd2 = ADDR_R2 == '0 ? R0_ZERO : (WRITE && ADDR_W == ADDR_R2) ? DATA_W : entry[ADDR_R2];
    register_32 u_r1 (.clk(CLK), .rst_n(RST), .en(READ), .d(rd1), .q(DATA_R1));
    register_32 u_r2 (.clk(CLK), .rst_n(RST), .en(READ), .d(rd2), .q(DATA_R2));
    always_ff @(posedge CLK or negedge RST)
        if (!RST) R_VALID <= 1'b0;
        else R_VALID <= READ;
endmodule

// File: tb/tb_register_file_2r1w.sv
// tb_register_file_2r1w: directed scoreboard bench for the 2R1W register file
module tb_register_file_2r1w;
    import register_file_2r1w_pkg::*;
    logic CLK = 0, RST = 0, READ = 0, WRITE = 0;
    logic [4:0] ADDR_R1 = 0, ADDR_R2 = 0, ADDR_W = 0;
    logic [31:0] DATA_W = 0;
    logic [31:0] DATA_R1, DATA_R2;
    logic R_VALID;
    int total = 0, bad = 0;
    logic [31:0] mdl [32];
    logic [31:0] h1 = 0, h2 = 0;
    logic [63:0] sb [$];

    register_file_2r1w dut (
        .CLK(CLK), .RST(RST), .READ(READ), .WRITE(WRITE),
        .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .DATA_R1(DATA_R1), .DATA_R2(DATA_R2), .R_VALID(R_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (mdl[k]) mdl[k] = 32'h0;
        mdl[SP_INDEX] = SP_RESET;
        h1 = 0;
        h2 = 0;
        sb.delete();
    endtask

    // one clock: drive, push expectation, model the edge, then compare #1 after it
    task automatic cyc(input logic rd, input logic wr, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] aw, input logic [31:0] dw, input string tag);
        logic [63:0] e;
        logic [31:0] e1, e2;
        READ = rd; WRITE = wr; ADDR_R1 = a1; ADDR_R2 = a2; ADDR_W = aw; DATA_W = dw;
        e1 = (a1 == 0) ? 32'h0 : (wr && aw == a1) ? dw : mdl[a1];
        e2 = (a2 == 0) ? 32'h0 : (wr && aw == a2) ? dw : mdl[a2];
        if (rd) sb.push_back({e1, e2});
        @(posedge CLK);
        if (wr && aw != 0) mdl[aw] = dw;
        #1;
        chk({tag, "_vld"}, {31'b0, R_VALID}, {31'b0, rd});
        if (rd) begin
            e = sb.pop_front();
            h1 = e[63:32];
            h2 = e[31:0];
        end
        chk({tag, "_r1"}, DATA_R1, h1);
        chk({tag, "_r2"}, DATA_R2, h2);
        READ = 0;
        WRITE = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        chk("rst_r1", DATA_R1, 32'h0);
        chk("rst_r2", DATA_R2, 32'h0);
        chk("rst_vld", {31'b0, R_VALID}, 32'h0);
        RST = 1;
        cyc(1, 0, 29, 0, 0, 32'h0, "t1");
        chk("t1_sp", DATA_R1, 32'h03FFFFFF);
        cyc(0, 1, 0, 0, 5, 32'hDEADBEEF, "t2w");
        cyc(1, 0, 5, 5, 0, 32'h0, "t2r");
        chk("t2_const", DATA_R2, 32'hDEADBEEF);
        cyc(1, 1, 0, 5, 0, 32'hFFFFFFFF, "t3");
        cyc(1, 0, 0, 0, 0, 32'h0, "t3b");
        chk("t3_zero", DATA_R1, 32'h0);
        cyc(0, 1, 0, 0, 7, 32'h11111111, "t4w7");
        cyc(0, 1, 0, 0, 8, 32'h0F0F0F0F, "t4w8");
        cyc(1, 1, 7, 8, 7, 32'h22222222, "t4");
        chk("t4_byp", DATA_R1, 32'h22222222);
        cyc(1, 0, 7, 8, 0, 32'h0, "t4after");
        cyc(1, 1, 9, 9, 9, 32'hA5A5A5A5, "byp2");
        cyc(1, 0, 5, 8, 0, 32'h0, "t5");
        repeat (3) cyc(0, 0, 7, 7, 0, 32'h0, "t5idle");
        for (int k = 0; k < 4; k++)
            cyc(1, 1, 5'(k + 10), 5'(k + 9), 5'(k + 10), $urandom, "b2b");
        cyc(0, 1, 0, 0, 3, 32'hCAFEF00D, "t6w3");
        cyc(0, 1, 0, 0, 29, 32'h12345678, "t6w29");
        cyc(1, 0, 3, 29, 0, 32'h0, "t6pre");
        #2;
        RST = 0;
        #1;
        chk("t6_async_r1", DATA_R1, 32'h0);
        chk("t6_async_r2", DATA_R2, 32'h0);
        chk("t6_async_vld", {31'b0, R_VALID}, 32'h0);
        model_reset();
        #3;
        RST = 1;
        cyc(1, 0, 3, 29, 0, 32'h0, "t6post");
        chk("t6_sp", DATA_R2, 32'h03FFFFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
